// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter in front of one single-port RAM.
// One access at a time; fixed read latency; all outputs registered.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              grant_d_q, grant_d_d;   // 1 = data port owns the current access
    logic              last_d_q, last_d_d;     // 1 = data port won the previous grant
    logic              m_en_q, m_en_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;
    logic              pick_data;
    logic              finish_read;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d_d   = grant_d_q;
        last_d_d    = last_d_q;
        m_en_d      = 1'b0;
        m_we_d      = 1'b0;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        pick_data   = 1'b0;
        finish_read = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // On conflict the port that did not win last time goes first.
                    pick_data = d_req && (!i_req || !last_d_q);
                    grant_d_d = pick_data;
                    last_d_d  = pick_data;
                    m_en_d    = 1'b1;
                    m_we_d    = pick_data && d_we;
                    m_addr_d  = pick_data ? d_addr : i_addr;
                    if (pick_data) begin
                        m_wdata_d = d_wdata;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (m_we_q) begin
                    d_ack_d = 1'b1;
                    state_d = RESP;
                end else if (LATENCY == 0) begin
                    finish_read = 1'b1;
                end else begin
                    cnt_d   = LAT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // A count of 0 can only come from corruption; finish rather than hang.
                if (cnt_q <= 4'd1) begin
                    finish_read = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finish_read) begin
            state_d = RESP;
            if (grant_d_q) begin
                d_rdata_d = m_rdata;
                d_ack_d   = 1'b1;
            end else begin
                i_rdata_d = m_rdata;
                i_ack_d   = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            grant_d_q <= 1'b0;
            last_d_q  <= 1'b0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_d_q <= grant_d_d;
            last_d_q  <= last_d_d;
            m_en_q    <= m_en_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            busy_q    <= busy_d;
        end
    end

    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign busy    = busy_q;
endmodule
